// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-input, W-bit round-robin arbitrated multiplexer.
// A single output register stage holds the granted word and its channel
// index (out_sel), giving 1-cycle latency and 1 word/cycle throughput.
//
// Handshake rule (all ports): a word moves on a rising edge exactly when
// valid and ready are both high in the cycle before that edge. The source
// keeps valid and data stable until the transfer. in_ready is computed
// combinationally from in_valid and out_ready, so upstream must never
// derive in_valid from in_ready.
module rr_arb_mux #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N-1:0]           in_valid,
   output logic [N-1:0]           in_ready,
   input  logic [N*W-1:0]         in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [W-1:0]           out_data,
   output logic [$clog2(N)-1:0]   out_sel
);

   localparam int SW = $clog2(N);
   localparam logic [SW-1:0] LAST = SW'(N - 1);

   logic [SW-1:0] ptr_q, ptr_d;
   logic [SW-1:0] sel_q, sel_d;
   logic [W-1:0]  data_q, data_d;
   logic          valid_q, valid_d;

   logic          any;
   logic          can_load;
   logic          hi_any;
   logic [SW-1:0] hi_idx;
   logic [SW-1:0] lo_idx;
   logic [SW-1:0] grant;
   logic [W-1:0]  grant_data;

   assign any      = |in_valid;
   assign can_load = !valid_q || out_ready;

   // Round-robin search: lowest requester at or above ptr, else lowest overall
   // (the wrapped part of the search ptr..N-1, 0..ptr-1).
   always_comb begin
      hi_any = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (in_valid[k]) begin
            lo_idx = SW'(k);
         end
         if (in_valid[k] && (SW'(k) >= ptr_q)) begin
            hi_idx = SW'(k);
            hi_any = 1'b1;
         end
      end
      grant = hi_any ? hi_idx : lo_idx;
   end

   // Select the granted channel's word; other channels never reach the outputs.
   always_comb begin
      grant_data = '0;
      for (int k = 0; k < N; k++) begin
         if (SW'(k) == grant) begin
            grant_data = in_data[k*W +: W];
         end
      end
   end

   // One-hot ready to the granted channel when the output register can load.
   always_comb begin
      in_ready = '0;
      if (rst && can_load && any) begin
         for (int k = 0; k < N; k++) begin
            in_ready[k] = (SW'(k) == grant);
         end
      end
   end

   // Next-state: load on grant, empty when drained with no requester, else hold.
   always_comb begin
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      data_d  = data_q;
      valid_d = valid_q;
      if (can_load) begin
         if (any) begin
            valid_d = 1'b1;
            data_d  = grant_data;
            sel_d   = grant;
            ptr_d   = (grant == LAST) ? '0 : grant + 1'b1;
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   // Output register and priority pointer; reset discards any held word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q   <= '0;
         sel_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed scenarios with literal expectations, then
// randomized traffic, all cross-checked every cycle against a behavioural
// model of the arbiter plus a word scoreboard.
module tb_rr_arb_mux;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int SW = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // ---------------- N=4 DUT ----------------
   logic [N-1:0]   in_valid = '0;
   logic [N-1:0]   in_ready;
   logic [N*W-1:0] in_data  = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [W-1:0]   out_data;
   logic [SW-1:0]  out_sel;

   rr_arb_mux #(.N(N), .W(W)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel)
   );

   // ---------------- N=3 DUT ----------------
   logic [2:0]  v3 = '0;
   logic [2:0]  r3;
   logic [23:0] d3 = '0;
   logic        ov3;
   logic        ordy3 = 1'b0;
   logic [7:0]  od3;
   logic [1:0]  os3;

   rr_arb_mux #(.N(3), .W(8)) u_dut3 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v3),
      .in_ready  (r3),
      .in_data   (d3),
      .out_valid (ov3),
      .out_ready (ordy3),
      .out_data  (od3),
      .out_sel   (os3)
   );

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (N=4) ----------------
   logic         m_valid = 1'b0;
   logic [W-1:0] m_data  = '0;
   int           m_sel   = 0;
   int           m_ptr   = 0;
   logic [W-1:0] exp_q[$];

   // First requester scanning ptr, ptr+1, ... modulo N; -1 when none.
   function automatic int m_grant(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_valid = 1'b0;
         m_data  = '0;
         m_sel   = 0;
         m_ptr   = 0;
         exp_q.delete();
      end else begin
         int g;
         g = m_grant(in_valid, m_ptr);
         if (!m_valid || out_ready) begin
            if (g >= 0) begin
               m_valid = 1'b1;
               m_data  = in_data[g*W +: W];
               m_sel   = g;
               m_ptr   = (g + 1) % N;
               exp_q.push_back(m_data);
            end else begin
               m_valid = 1'b0;
            end
         end
      end
   end

   // Compare process: every falling edge, outputs and ready vs the model.
   always @(negedge clk) begin
      int g;
      logic [N-1:0] exp_rdy;
      g = m_grant(in_valid, m_ptr);
      exp_rdy = '0;
      if (rst && (!m_valid || out_ready) && g >= 0) exp_rdy[g] = 1'b1;
      check("m_in_ready", 32'(in_ready), 32'(exp_rdy));
      check("m_out_valid", 32'(out_valid), 32'(m_valid));
      check("m_out_data", 32'(out_data), 32'(m_data));
      check("m_out_sel", 32'(out_sel), 32'(m_sel));
      check("n3_sel_range", 32'(os3 < 2'd3), 32'd1);
      if (rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 32'd1);
         end else begin
            check("sb_word", 32'(out_data), 32'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int k, input logic [W-1:0] d);
      in_data[k*W +: W] = d;
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Test 1: reset held with random inputs.
      for (int i = 0; i < 3; i++) begin
         tick();
         in_valid  = N'($urandom_range(0, 15));
         in_data   = $urandom;
         out_ready = 1'($urandom_range(0, 1));
         v3        = 3'($urandom_range(0, 7));
         #1;
         check("rst_in_ready", 32'(in_ready), 32'd0);
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_out_data", 32'(out_data), 32'd0);
         check("rst_out_sel", 32'(out_sel), 32'd0);
      end
      tick();
      in_valid = '0;
      v3       = '0;
      rst      = 1'b1;
      tick();
      check("rel_out_valid", 32'(out_valid), 32'd0);
      check("rel_out_sel", 32'(out_sel), 32'd0);

      // Test 2: single channel 2, then ptr must sit at 3.
      in_valid  = 4'b0100;
      set_ch(2, 8'hA5);
      out_ready = 1'b1;
      #1;
      check("single_in_ready", 32'(in_ready), 32'b0100);
      tick();
      check("single_out_valid", 32'(out_valid), 32'd1);
      check("single_out_data", 32'(out_data), 32'hA5);
      check("single_out_sel", 32'(out_sel), 32'd2);
      in_valid = 4'b1111;
      #1;
      check("single_ptr3", 32'(in_ready), 32'b1000);

      // Test 3: all channels requesting after reset, sel 0,1,2,3,0,1.
      for (int k = 0; k < N; k++) set_ch(k, W'(8'hA0 + k));
      pulse_reset();
      #1;
      check("rr_first_ready", 32'(in_ready), 32'b0001);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("rr_valid", 32'(out_valid), 32'd1);
         check("rr_sel", 32'(out_sel), 32'(i % 4));
         check("rr_data", 32'(out_data), 32'(8'hA0 + (i % 4)));
      end
      // Test 6: asynchronous reset mid-stream.
      rst = 1'b0;
      #1;
      check("async_valid_drop", 32'(out_valid), 32'd0);
      rst = 1'b1;
      tick();
      check("post_rst_sel", 32'(out_sel), 32'd0);
      check("post_rst_data", 32'(out_data), 32'hA0);

      // Test 4: backpressure with channel 1 word held.
      pulse_reset();
      in_valid  = 4'b0010;
      set_ch(1, 8'h11);
      set_ch(0, 8'h5A);
      out_ready = 1'b0;
      tick();
      check("bp_load_data", 32'(out_data), 32'h11);
      in_valid = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_in_ready", 32'(in_ready), 32'd0);
         tick();
         check("bp_hold_data", 32'(out_data), 32'h11);
         check("bp_hold_sel", 32'(out_sel), 32'd1);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(in_ready), 32'b0001);
      tick();
      check("bp_new_data", 32'(out_data), 32'h5A);
      check("bp_new_sel", 32'(out_sel), 32'd0);
      in_valid = '0;
      tick();
      check("bp_drained", 32'(out_valid), 32'd0);

      // Test 5: N=3 round-robin wraps 2 -> 0.
      pulse_reset();
      d3    = {8'h32, 8'h31, 8'h30};
      v3    = 3'b111;
      ordy3 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("n3_valid", 32'(ov3), 32'd1);
         check("n3_sel", 32'(os3), 32'(i % 3));
         check("n3_data", 32'(od3), 32'(8'h30 + (i % 3)));
      end
      v3 = '0;

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         tick();
         in_valid  = N'($urandom_range(0, 15));
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) pulse_reset();
      end
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- N-input, W-bit round-robin arbitrated multiplexer with valid/ready handshakes on every input and on the single output.
- Sits directly upstream of the combinational mux stage. It produces the registered select (out_sel) that drives that stage's sel input, and the registered data word.
- A single output register stage gives 1-cycle latency and full throughput of 1 word/cycle.

Parameters:
- N, 4: number of input channels, N >= 2; need not be a power of 2.
- W, 8: data width in bits.
- SW, $clog2(N) (derived, localparam): select/pointer width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  N  bit k: channel k offers a word.
- in_ready  output  N  bit k: channel k's word is taken this cycle.
- in_data  input  N*W  channel k occupies bits [k*W +: W].
- out_valid  output  1  out_data/out_sel hold a valid word.
- out_ready  input  1  downstream accepts the word this cycle.
- out_data  output  W  registered selected word.
- out_sel  output  SW  registered index of the channel that supplied out_data.

Behaviour:
- Reset (rst=0, asynchronous assert, released synchronously by the environment):
  - out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0.
  - in_ready=0 while rst=0.
- can_load = !out_valid || out_ready (output register empty, or being drained this cycle).
- Grant, combinational:
  - g = first k with in_valid[k]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - any = |in_valid.
- in_ready[k] = can_load && any && (k == g). At most one bit is set (one-hot or zero). in_ready depends combinationally on in_valid and out_ready; upstream must not make in_valid depend on in_ready.
- Transfer: input k transfers when in_valid[k] && in_ready[k]. Output transfers when out_valid && out_ready.
- Per clock edge:
  - can_load && any: out_data<=in_data[g]; out_sel<=g; out_valid<=1; ptr<=(g==N-1)?0:g+1.
  - can_load && !any: out_valid<=0; out_data, out_sel and ptr hold.
  - !can_load (stall): all registers hold. out_data/out_sel stay stable while out_valid=1 and out_ready=0.
- Simultaneous drain and load in the same cycle: the new word replaces the old one with no bubble, giving back-to-back throughput.
- Fairness:
  - ptr advances only on a grant, and only to the slot after the granted one.
  - A continuously asserted channel waits at most N-1 grants.
- Wrap-around: ptr wraps from N-1 to 0. Encodings N..2^SW-1 never occur in ptr or out_sel (matters for non-power-of-2 N).
- Latency: input handshake at edge t makes out_valid=1 with that word after edge t.
- out_ready while out_valid=0 is ignored.
- Reset mid-transfer: any word in the output register is discarded; ptr returns to 0.
- No X propagation: in_data of non-granted channels never reaches the outputs.

Test Plan:
1. Reset: hold rst=0 with random inputs. Expect out_valid=0, out_sel=0, out_data=0, in_ready=0. Release rst with in_valid=0 → outputs unchanged.
2. Single channel, N=4, W=8: in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1. Expect in_ready=4'b0100. Next cycle out_valid=1, out_data=8'hA5, out_sel=2, ptr=3.
3. Round-robin: in_valid=4'b1111 constantly, distinct data per channel, out_ready=1. Expect out_sel sequence 0,1,2,3,0,1 with one word per cycle and no bubbles.
4. Backpressure: out_valid=1 holding out_data=8'h11 from channel 1, out_ready=0 for 3 cycles, in_valid=4'b0001. Expect in_ready=0, out_data/out_sel stable. Raise out_ready → in_ready=4'b0001 that cycle; next cycle out_data is channel 0's word, out_sel=0.
5. Non-power-of-2, N=3: in_valid=3'b111 constantly. Expect out_sel 0,1,2,0; ptr never equals 3.
6. Reset mid-stream: during test 3, pulse rst low between edges. Expect out_valid to drop immediately (asynchronous). After release, first grant goes to channel 0.
